fractal_sync_rf_port_sched: RTL

Scheduler that shares the N_PORTS check ports of one 1D local synchronization register file among N_REQS requesters (e.g. child nodes of a fractal tree level).
- Each requester pushes barrier ids through a valid/ready handshake into a private FIFO.
- Each cycle, up to N_PORTS FIFO heads are granted round-robin and driven onto the RF ports.
- The RF's same-cycle present/id_err/bypass/ignore results are registered and returned to the owning requester one cycle later.

---
 rtl/fractal_sync_rf_port_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_rf_port_sched.sv
// fractal_sync_rf_port_sched
// Shares the check ports of one 1D local synchronization register file among
// several requesters. Each requester owns a small FIFO of barrier ids. Every
// cycle, up to N_PORTS non-empty FIFO heads are granted round-robin onto the RF
// ports. The RF's same-cycle result flags are registered and sent back to the
// requester that owns each port, one cycle later.

module fractal_sync_rf_port_sched #(
  parameter int unsigned N_REQS     = 4,
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_REQS-1:0]                   req_valid_i,
  input  logic [N_REQS-1:0][ID_WIDTH-1:0]     req_id_i,
  output logic [N_REQS-1:0]                   req_ready_o,
  output logic [N_REQS-1:0]                   rsp_valid_o,
  output logic [N_REQS-1:0]                   rsp_present_o,
  output logic [N_REQS-1:0]                   rsp_id_err_o,
  output logic [N_REQS-1:0]                   rsp_bypass_o,
  output logic [N_REQS-1:0]                   rsp_ignore_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]    rf_id_o,
  output logic [N_PORTS-1:0]                  rf_check_o,
  input  logic [N_PORTS-1:0]                  rf_present_i,
  input  logic [N_PORTS-1:0]                  rf_id_err_i,
  input  logic [N_PORTS-1:0]                  rf_bypass_i,
  input  logic [N_PORTS-1:0]                  rf_ignore_i
);

  localparam int unsigned RR_W   = (N_REQS > 1) ? $clog2(N_REQS) : 1;
  localparam int unsigned PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned NCNT_W = $clog2(N_PORTS + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  // Parameter sanity, rejected at elaboration.
  if (N_REQS < N_PORTS) begin : g_chk_reqs
    $fatal(1, "fractal_sync_rf_port_sched: N_REQS must be >= N_PORTS");
  end
  if (N_PORTS < 2) begin : g_chk_ports
    $fatal(1, "fractal_sync_rf_port_sched: N_PORTS must be >= 2");
  end
  if (ID_WIDTH < 1) begin : g_chk_id
    $fatal(1, "fractal_sync_rf_port_sched: ID_WIDTH must be > 0");
  end
  if (FIFO_DEPTH < 1) begin : g_chk_depth
    $fatal(1, "fractal_sync_rf_port_sched: FIFO_DEPTH must be >= 1");
  end

  // Per-requester FIFO storage and bookkeeping.
  logic [ID_WIDTH-1:0]                fifo_mem_q [N_REQS][FIFO_DEPTH];
  logic [N_REQS-1:0][PTR_W-1:0]       rd_ptr_q;
  logic [N_REQS-1:0][PTR_W-1:0]       wr_ptr_q;
  logic [N_REQS-1:0][CNT_W-1:0]       count_q;

  logic [N_REQS-1:0]                  full_s;
  logic [N_REQS-1:0]                  empty_s;
  logic [N_REQS-1:0]                  push_s;
  logic [N_REQS-1:0][ID_WIDTH-1:0]    head_id_s;

  // Grant results: which requesters won a port and which port each won.
  logic [N_REQS-1:0]                  grant_s;
  logic [N_REQS-1:0][PORT_W-1:0]      port_sel_s;

  logic [RR_W-1:0]                    rr_q;
  logic [RR_W-1:0]                    rr_next_s;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    nxt = (ptr == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : (ptr + PTR_W'(1));
    return nxt;
  endfunction

  // Ready depends only on stored occupancy, never on a same-cycle pop.
  assign req_ready_o = ~full_s;

  // FIFO status, head id and accepted pushes.
  always_comb begin
    full_s    = '0;
    empty_s   = '0;
    push_s    = '0;
    head_id_s = '0;
    for (int i = 0; i < N_REQS; i++) begin
      full_s[i]    = (count_q[i] == CNT_W'(FIFO_DEPTH));
      empty_s[i]   = (count_q[i] == {CNT_W{1'b0}});
      head_id_s[i] = fifo_mem_q[i][rd_ptr_q[i]];
      push_s[i]    = req_valid_i[i] & ~full_s[i];
    end
  end

  // Round-robin scan from rr_q: the first N_PORTS non-empty heads take ports 0,1,...
  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W:0]   wrapped;
    logic [RR_W-1:0] idx;
    logic [NCNT_W-1:0] n_used;
    sum        = '0;
    wrapped    = '0;
    idx        = '0;
    n_used     = '0;
    grant_s    = '0;
    port_sel_s = '0;
    rf_check_o = '0;
    rf_id_o    = '0;
    rr_next_s  = rr_q;
    for (int k = 0; k < N_REQS; k++) begin
      sum     = {1'b0, rr_q} + (RR_W + 1)'(k);
      wrapped = (sum >= (RR_W + 1)'(N_REQS)) ? (sum - (RR_W + 1)'(N_REQS)) : sum;
      idx     = wrapped[RR_W-1:0];
      if (!empty_s[idx] && (n_used < NCNT_W'(N_PORTS))) begin
        grant_s[idx]                   = 1'b1;
        port_sel_s[idx]                = n_used[PORT_W-1:0];
        rf_check_o[n_used[PORT_W-1:0]] = 1'b1;
        rf_id_o[n_used[PORT_W-1:0]]    = head_id_s[idx];
        rr_next_s = (idx == RR_W'(N_REQS - 1)) ? {RR_W{1'b0}} : (idx + RR_W'(1));
        n_used    = n_used + NCNT_W'(1);
      end else begin
        // Empty FIFO or all ports already taken: this requester waits.
        n_used = n_used;
      end
    end
  end

  // FIFO write on accepted push, read on grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REQS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) begin
          fifo_mem_q[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_REQS; i++) begin
        if (push_s[i]) begin
          fifo_mem_q[i][wr_ptr_q[i]] <= req_id_i[i];
          wr_ptr_q[i]                <= ptr_inc(wr_ptr_q[i]);
        end
        if (grant_s[i]) begin
          rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        end
        count_q[i] <= count_q[i] + CNT_W'(push_s[i]) - CNT_W'(grant_s[i]);
      end
    end
  end

  // Round-robin pointer moves past the last winner; holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_next_s;
    end
  end

  // Route each port's RF result back to the requester that owned the port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o   <= '0;
      rsp_present_o <= '0;
      rsp_id_err_o  <= '0;
      rsp_bypass_o  <= '0;
      rsp_ignore_o  <= '0;
    end else begin
      for (int i = 0; i < N_REQS; i++) begin
        rsp_valid_o[i]   <= grant_s[i];
        rsp_present_o[i] <= grant_s[i] & rf_present_i[port_sel_s[i]];
        rsp_id_err_o[i]  <= grant_s[i] & rf_id_err_i[port_sel_s[i]];
        rsp_bypass_o[i]  <= grant_s[i] & rf_bypass_i[port_sel_s[i]];
        rsp_ignore_o[i]  <= grant_s[i] & rf_ignore_i[port_sel_s[i]];
      end
    end
  end

endmodule
